// File: rtl/seq_down_timer.sv
// Loadable down-counting timer: valid/ready load, pause, abort, optional
// auto-reload, registered one-cycle done pulse and a wrapping expiry counter.
module seq_down_timer #(
  parameter int WIDTH = 8,
  parameter int EVT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done,
  output logic [EVT_W-1:0] event_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] count_reg,  count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             done_reg,   done_next;
  logic [EVT_W-1:0] evt_reg,    evt_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      done_reg   <= 1'b0;
      evt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      done_reg   <= done_next;
      evt_reg    <= evt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    done_next   = 1'b0;
    evt_next    = evt_reg;
    unique case (state_reg)
      IDLE: begin
        if (load_valid) begin
          count_next  = load_value;
          reload_next = load_value;
          if (load_value != '0) begin
            state_next = RUN;
          end else begin
            // A zero load expires immediately without ever leaving IDLE
            done_next = 1'b1;
            evt_next  = evt_reg + 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
        end else if (pause) begin
          state_next = PAUSE;
        end else if (count_reg == WIDTH'(1)) begin
          done_next = 1'b1;
          evt_next  = evt_reg + 1'b1;
          if (auto_reload) begin
            count_next = reload_reg;
          end else begin
            count_next = '0;
            state_next = IDLE;
          end
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      PAUSE: begin
        // Resuming costs one edge: no decrement on the PAUSE->RUN transition
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
        end else if (!pause) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign load_ready  = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign count_out   = count_reg;
  assign done        = done_reg;
  assign event_count = evt_reg;

endmodule

// File: tb/tb_seq_down_timer.sv
// Directed self-checking bench for seq_down_timer: one-shot, auto-reload wrap,
// pause, abort, async reset mid-run, pause-over-expiry and zero load.
module tb_seq_down_timer;

  logic       clk;
  logic       reset_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic       auto_reload;
  logic       pause;
  logic       abort;
  logic [7:0] count_out;
  logic       busy;
  logic       done;
  logic [1:0] event_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_cnt  [8];
  logic       exp_done [8];
  logic [1:0] exp_evt  [8];

  seq_down_timer #(.WIDTH(8), .EVT_W(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .pause       (pause),
    .abort       (abort),
    .count_out   (count_out),
    .busy        (busy),
    .done        (done),
    .event_count (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_cnt  = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    exp_done = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_evt  = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};

    reset_n = 1'b1; load_valid = 1'b0; load_value = 8'd0;
    auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_count", count_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", load_ready, 1);
    check("rst_done", done, 0);
    check("rst_evt", event_count, 0);
    tick();
    reset_n = 1'b1;

    // one-shot load 3; a load attempted while running is ignored
    load_valid = 1'b1; load_value = 8'd3;
    tick();
    check("t1_e0_count", count_out, 3);
    check("t1_e0_busy", busy, 1);
    check("t1_e0_ready", load_ready, 0);
    check("t1_e0_done", done, 0);
    load_value = 8'd7;
    tick();
    check("t1_e1_count", count_out, 2);
    load_valid = 1'b0;
    tick();
    check("t1_e2_count", count_out, 1);
    check("t1_e2_done", done, 0);
    tick();
    check("t1_e3_count", count_out, 0);
    check("t1_e3_done", done, 1);
    check("t1_e3_busy", busy, 0);
    check("t1_e3_ready", load_ready, 1);
    check("t1_e3_evt", event_count, 1);
    tick();
    check("t1_e4_done", done, 0);

    // auto-reload period 2, event counter wraps
    auto_reload = 1'b1; load_valid = 1'b1; load_value = 8'd2;
    tick();
    check("t2_e0_count", count_out, 2);
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t2_e%0d_count", k + 1), count_out, exp_cnt[k]);
      check($sformatf("t2_e%0d_done", k + 1), done, exp_done[k]);
      check($sformatf("t2_e%0d_evt", k + 1), event_count, exp_evt[k]);
    end
    auto_reload = 1'b0;
    tick();
    check("t2_stop_count1", count_out, 1);
    check("t2_stop_busy1", busy, 1);
    tick();
    check("t2_stop_done", done, 1);
    check("t2_stop_busy", busy, 0);
    check("t2_stop_evt", event_count, 2);

    // pause for two edges after the first decrement
    load_valid = 1'b1; load_value = 8'd4;
    tick();
    check("t3_e0_count", count_out, 4);
    load_valid = 1'b0;
    tick();
    check("t3_e1_count", count_out, 3);
    pause = 1'b1;
    tick();
    check("t3_p1_count", count_out, 3);
    check("t3_p1_busy", busy, 1);
    tick();
    check("t3_p2_count", count_out, 3);
    pause = 1'b0;
    tick();
    check("t3_resume_count", count_out, 3);
    tick();
    check("t3_c2", count_out, 2);
    tick();
    check("t3_c1", count_out, 1);
    check("t3_c1_done", done, 0);
    tick();
    check("t3_done", done, 1);
    check("t3_count0", count_out, 0);
    check("t3_evt", event_count, 3);

    // asynchronous reset mid-run, checked between clock edges
    load_valid = 1'b1; load_value = 8'd5;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    check("t6_pre_count", count_out, 3);
    #2 reset_n = 1'b0;
    #1;
    check("t6_count", count_out, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", load_ready, 1);
    check("t6_done", done, 0);
    check("t6_evt", event_count, 0);
    tick();
    check("t6_hold_count", count_out, 0);
    reset_n = 1'b1;

    // abort on the cycle count_out==1
    load_valid = 1'b1; load_value = 8'd5;
    tick();
    load_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("t4_pre_count", count_out, 1);
    abort = 1'b1;
    tick();
    check("t4_count", count_out, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_evt", event_count, 0);
    abort = 1'b0;
    tick();
    check("t4_done_after", done, 0);

    // pause wins over a same-cycle expiry
    load_valid = 1'b1; load_value = 8'd1;
    tick();
    load_valid = 1'b0;
    pause = 1'b1;
    tick();
    check("pw_count", count_out, 1);
    check("pw_done", done, 0);
    check("pw_busy", busy, 1);
    pause = 1'b0;
    tick();
    check("pw_resume_count", count_out, 1);
    tick();
    check("pw_done_late", done, 1);
    check("pw_evt", event_count, 1);

    // zero load expires without leaving IDLE
    load_valid = 1'b1; load_value = 8'd0;
    tick();
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    check("t5_ready", load_ready, 1);
    check("t5_count", count_out, 0);
    check("t5_evt", event_count, 2);
    load_valid = 1'b0;
    tick();
    check("t5_done_after", done, 0);
    check("t5_evt_after", event_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
